pixel_lfsr_scrambler: RTL and testbench
=======================================

# pixel_lfsr_scrambler

Parametrised, frame-synchronous LFSR scrambler/descrambler for the camera pixel stream. It XORs each valid pixel with an LFSR keystream. The keystream advances only on valid pixels (href high) and is reseeded at every frame start (vsync rising edge). New seeds arrive through a valid/ready handshake and are staged until the next frame boundary, so master and slave stay aligned per frame. It sits between the camera pixel interface and the display/port logic, on both the scrambling and descrambling sides, because XOR is symmetric.

## Interface
Parameters:
- DATA_W, 12: pixel width and LFSR width (≥4).
- TAPS, 12'h829: feedback tap mask (default bits 11,5,3,0).
- RESET_SEED, 12'h001: seed loaded at reset; must be nonzero.
- RESEED_EACH_FRAME, 1: 1 = reload the active seed at every vsync edge; 0 = free-run across frames, reload only when a pending seed exists.

Ports:
- clk  in  1  pixel clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  1 = scramble valid pixels; 0 = bypass (data passes unmodified, LFSR still advances).
- i_data  in  DATA_W  pixel in.
- i_href  in  1  pixel valid / line active.
- i_vsync  in  1  frame sync; its rising edge marks the frame start.
- seed_data  in  DATA_W  new seed.
- seed_valid  in  1  seed offered.
- seed_ready  out  1  = ~pending_valid (combinational).
- o_data  out  DATA_W  scrambled pixel, registered.
- o_href  out  1  i_href delayed 1 cycle.
- o_vsync  out  1  i_vsync delayed 1 cycle.
- frame_cnt  out  16  count of vsync rising edges, wraps at 0xFFFF→0.

## Operation
- State: lfsr, active_seed, pending_seed, pending_valid, vsync_d, output registers, frame_cnt.
- Feedback: fb = ^(lfsr & TAPS); step = {fb, lfsr[DATA_W-1:1]}.
- The key for a pixel is the current lfsr value, before that cycle's step.
- vs_edge = i_vsync & ~vsync_d. vsync_d resets to 0.
- Seed handshake: a seed is accepted when seed_valid & seed_ready. On acceptance, pending_seed <= (seed_data==0 ? 1 : seed_data) and pending_valid <= 1. An all-zero seed is replaced by 1 to avoid LFSR lock-up.
- On vs_edge:
  - If pending_valid: lfsr <= pending_seed, active_seed <= pending_seed, pending_valid <= 0.
  - Else if RESEED_EACH_FRAME: lfsr <= active_seed.
  - Else: lfsr is held (no step).
  - In all cases: frame_cnt <= frame_cnt+1.
- Else if i_href: lfsr <= step.
- Else: lfsr is held.
- Output register: o_data <= (en & i_href) ? i_data ^ lfsr : i_data. o_href <= i_href. o_vsync <= i_vsync.

## Timing
- Latency is 1 cycle from input to o_data/o_href/o_vsync. Throughput is 1 pixel per clk.
- Reset values (while reset=0):
  - lfsr = active_seed = RESET_SEED; pending_valid = 0, so seed_ready = 1.
  - o_data = 0, o_href = 0, o_vsync = 0, frame_cnt = 0, vsync_d = 0.
- Reset is asserted asynchronously and released synchronously by the integrator. Reset mid-frame discards any pending seed and returns the keystream to RESET_SEED.
- vs_edge coinciding with i_href: that pixel uses the old lfsr; the reload wins over the step.
- Handshake on the vs_edge cycle while pending_valid=0: the reload uses the prior state (active_seed or hold). The new seed becomes pending and applies at the next edge.
- While pending_valid=1, seed_ready=0. Further seeds stall until the next vs_edge clears pending_valid; seed_ready rises the cycle after.
- vsync held high: only the first cycle is an edge. A level does not retrigger.
- Toggling en mid-line affects only the XOR. The keystream position is unchanged, so the descrambler stays in step.

## Test plan
- Keystream: reset (RESET_SEED=0x001), pulse vsync, then 4 href pixels with i_data=0x000 and en=1 -> o_data = 0x001, 0x800, 0xC00, 0xE00, each one cycle after input.
- Round trip: chain two instances with equal seeds and drive random pixels for 3 frames with gaps in href -> second instance o_data equals the original i_data, delayed 2 cycles.
- Seed staging: offer seed 0x5A5 mid-frame -> seed_ready drops the next cycle and the current frame's keystream is unchanged. The next vs_edge loads 0x5A5, so the first pixel key is 0x5A5 and seed_ready returns to 1.
- Zero seed and collision: offer 0x000 on the vs_edge cycle -> the current frame reloads the old active_seed. The next frame's first key is 0x001.
- RESEED_EACH_FRAME=0 with no pending seed: frame 2's first key continues from frame 1's last step. frame_cnt = 2.
- Async reset mid-line with a pending seed: o_data/o_href/o_vsync drop to 0 immediately, seed_ready=1, and the next frame's first key is RESET_SEED.

Source files
------------

// File: rtl/pixel_lfsr_scrambler.sv
// Frame-synchronous LFSR scrambler/descrambler: XORs valid pixels with a keystream reseeded at vsync.
// Latency: 1 clk from i_data/i_href/i_vsync to o_data/o_href/o_vsync; 1 pixel per clk.
// Backpressure: none on the pixel path; seed_ready drops while a staged seed awaits the next frame edge.
module pixel_lfsr_scrambler #(
    parameter int                DATA_W            = 12,
    parameter logic [DATA_W-1:0] TAPS              = 12'h829,
    parameter logic [DATA_W-1:0] RESET_SEED        = 12'h001,
    parameter bit                RESEED_EACH_FRAME = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_href,
    input  logic              i_vsync,
    input  logic [DATA_W-1:0] seed_data,
    input  logic              seed_valid,
    output logic              seed_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_href,
    output logic              o_vsync,
    output logic [15:0]       frame_cnt
);

    // An all-zero seed would lock the LFSR, so it is replaced by this value.
    localparam logic [DATA_W-1:0] SEED_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] lfsr;
    logic [DATA_W-1:0] lfsr_step;
    logic [DATA_W-1:0] active_seed;
    logic [DATA_W-1:0] pending_seed;
    logic              pending_valid;
    logic              vsync_d;
    logic              vs_edge;
    logic              seed_fire;
    logic              fb;

    // Only one seed can be staged; the next one waits until the frame edge consumes it.
    assign seed_ready = ~pending_valid;

    // Feedback, frame-edge detect and handshake qualification.
    always_comb begin
        fb        = ^(lfsr & TAPS);
        lfsr_step = {fb, lfsr[DATA_W-1:1]};
        vs_edge   = i_vsync & ~vsync_d;
        seed_fire = seed_valid & seed_ready;
    end

    // Keystream state: reload at frame start wins over a step; steps only on valid pixels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr          <= RESET_SEED;
            active_seed   <= RESET_SEED;
            pending_seed  <= RESET_SEED;
            pending_valid <= 1'b0;
            vsync_d       <= 1'b0;
        end else begin
            vsync_d <= i_vsync;
            // seed_fire implies pending_valid=0, so it never collides with the clear below.
            if (seed_fire) begin
                pending_seed  <= (seed_data == '0) ? SEED_ONE : seed_data;
                pending_valid <= 1'b1;
            end
            if (vs_edge) begin
                if (pending_valid) begin
                    lfsr          <= pending_seed;
                    active_seed   <= pending_seed;
                    pending_valid <= 1'b0;
                end else if (RESEED_EACH_FRAME) begin
                    lfsr <= active_seed;
                end
            end else if (i_href) begin
                lfsr <= lfsr_step;
            end
        end
    end

    // Output register: key is the pre-step lfsr value; bypass when disabled or between pixels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_data  <= '0;
            o_href  <= 1'b0;
            o_vsync <= 1'b0;
        end else begin
            o_data  <= (en && i_href) ? (i_data ^ lfsr) : i_data;
            o_href  <= i_href;
            o_vsync <= i_vsync;
        end
    end

    // Frame counter: one increment per vsync rising edge, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= 16'd0;
        end else if (vs_edge) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pixel_lfsr_scrambler.sv
// Directed bench for pixel_lfsr_scrambler: scrambler, chained descrambler, free-running variant.
// Latency: outputs are checked #1 after the edge that registers the inputs applied before it.
// Backpressure: seed_ready is checked combinationally around staged-seed and stall scenarios.
module tb_pixel_lfsr_scrambler;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic [W-1:0] i_data;
    logic         i_href;
    logic         i_vsync;
    logic [W-1:0] seed_data;
    logic         seed_valid;
    logic [W-1:0] no_seed_data;
    logic         no_seed_valid;
    logic         desc_en;

    logic         seed_ready;
    logic [W-1:0] o_data;
    logic         o_href;
    logic         o_vsync;
    logic [15:0]  frame_cnt;

    logic         d_seed_ready;
    logic [W-1:0] d_data;
    logic         d_href;
    logic         d_vsync;
    logic [15:0]  d_frame_cnt;

    logic         f_seed_ready;
    logic [W-1:0] f_data;
    logic         f_href;
    logic         f_vsync;
    logic [15:0]  f_frame_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pixel_lfsr_scrambler u_dut (
        .clk(clk), .reset(reset), .en(en), .i_data(i_data), .i_href(i_href), .i_vsync(i_vsync),
        .seed_data(seed_data), .seed_valid(seed_valid), .seed_ready(seed_ready),
        .o_data(o_data), .o_href(o_href), .o_vsync(o_vsync), .frame_cnt(frame_cnt)
    );

    pixel_lfsr_scrambler u_desc (
        .clk(clk), .reset(reset), .en(desc_en), .i_data(o_data), .i_href(o_href), .i_vsync(o_vsync),
        .seed_data(no_seed_data), .seed_valid(no_seed_valid), .seed_ready(d_seed_ready),
        .o_data(d_data), .o_href(d_href), .o_vsync(d_vsync), .frame_cnt(d_frame_cnt)
    );

    pixel_lfsr_scrambler #(.RESEED_EACH_FRAME(1'b0)) u_free (
        .clk(clk), .reset(reset), .en(en), .i_data(i_data), .i_href(i_href), .i_vsync(i_vsync),
        .seed_data(no_seed_data), .seed_valid(no_seed_valid), .seed_ready(f_seed_ready),
        .o_data(f_data), .o_href(f_href), .o_vsync(f_vsync), .frame_cnt(f_frame_cnt)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vs, input logic hr, input logic [W-1:0] d);
        i_vsync = vs;
        i_href  = hr;
        i_data  = d;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b1; drive(1'b0, 1'b0, 12'h000);
        seed_data = '0; seed_valid = 1'b0;
        cyc(); cyc();
        checks++; if (o_data !== 12'h000) begin errors++; $display("FAIL reset_o_data: got %h want 000", o_data); end
        checks++; if (o_href !== 1'b0) begin errors++; $display("FAIL reset_o_href: got %b want 0", o_href); end
        checks++; if (o_vsync !== 1'b0) begin errors++; $display("FAIL reset_o_vsync: got %b want 0", o_vsync); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
        checks++; if (seed_ready !== 1'b1) begin errors++; $display("FAIL reset_seed_ready: got %b want 1", seed_ready); end
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_keystream();
        logic [W-1:0] exp_key [4];
        exp_key[0] = 12'h001; exp_key[1] = 12'h800; exp_key[2] = 12'hC00; exp_key[3] = 12'hE00;
        drive(1'b1, 1'b0, 12'h000);
        cyc();
        checks++; if (o_vsync !== 1'b1) begin errors++; $display("FAIL ks_o_vsync: got %b want 1", o_vsync); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL ks_frame_cnt: got %0d want 1", frame_cnt); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 12'h000);
            cyc();
            checks++; if (o_data !== exp_key[i]) begin errors++; $display("FAIL ks_key%0d: got %h want %h", i, o_data, exp_key[i]); end
            checks++; if (o_href !== 1'b1) begin errors++; $display("FAIL ks_href%0d: got %b want 1", i, o_href); end
        end
    endtask

    // Scrambler reloads 0x001; the free-running copy continues from 0xF00.
    task automatic test_free_run();
        drive(1'b0, 1'b0, 12'h000); cyc();
        drive(1'b1, 1'b0, 12'h000); cyc();
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL fr_frame_cnt: got %0d want 2", frame_cnt); end
        checks++; if (f_frame_cnt !== 16'd2) begin errors++; $display("FAIL fr_free_frame_cnt: got %0d want 2", f_frame_cnt); end
        drive(1'b0, 1'b1, 12'h000); cyc();
        checks++; if (o_data !== 12'h001) begin errors++; $display("FAIL fr_reseed_key: got %h want 001", o_data); end
        checks++; if (f_data !== 12'hF00) begin errors++; $display("FAIL fr_continue_key: got %h want F00", f_data); end
    endtask

    // en only gates the XOR; href low passes data and holds the keystream.
    task automatic test_bypass();
        en = 1'b0; drive(1'b0, 1'b1, 12'h123); cyc();
        checks++; if (o_data !== 12'h123) begin errors++; $display("FAIL byp_en0: got %h want 123", o_data); end
        en = 1'b1; drive(1'b0, 1'b1, 12'h000); cyc();
        checks++; if (o_data !== 12'hC00) begin errors++; $display("FAIL byp_en1_key: got %h want C00", o_data); end
        checks++; if (f_data !== 12'hFC0) begin errors++; $display("FAIL byp_free_key: got %h want FC0", f_data); end
        drive(1'b0, 1'b0, 12'hABC); cyc();
        checks++; if (o_data !== 12'hABC) begin errors++; $display("FAIL byp_href0: got %h want ABC", o_data); end
        drive(1'b0, 1'b1, 12'h000); cyc();
        checks++; if (o_data !== 12'hE00) begin errors++; $display("FAIL byp_held_key: got %h want E00", o_data); end
    endtask

    // Edge pixel uses the old key; a held-high vsync is not a second edge.
    task automatic test_vsync_collision();
        drive(1'b1, 1'b1, 12'h000); cyc();
        checks++; if (o_data !== 12'hF00) begin errors++; $display("FAIL col_edge_key: got %h want F00", o_data); end
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL col_frame_cnt: got %0d want 3", frame_cnt); end
        drive(1'b1, 1'b1, 12'h000); cyc();
        checks++; if (o_data !== 12'h001) begin errors++; $display("FAIL col_level_key: got %h want 001", o_data); end
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL col_level_cnt: got %0d want 3", frame_cnt); end
        drive(1'b0, 1'b0, 12'h000); cyc();
    endtask

    task automatic test_seed_staging();
        seed_data = 12'h5A5; seed_valid = 1'b1; drive(1'b0, 1'b1, 12'h000);
        #1;
        checks++; if (seed_ready !== 1'b1) begin errors++; $display("FAIL stg_ready_before: got %b want 1", seed_ready); end
        cyc();
        seed_valid = 1'b0;
        checks++; if (o_data !== 12'h800) begin errors++; $display("FAIL stg_key0: got %h want 800", o_data); end
        checks++; if (seed_ready !== 1'b0) begin errors++; $display("FAIL stg_ready_drop: got %b want 0", seed_ready); end
        cyc();
        checks++; if (o_data !== 12'hC00) begin errors++; $display("FAIL stg_key1: got %h want C00", o_data); end
        // Second seed offered while one is staged: must stall, then be taken after the edge.
        seed_data = 12'h111; seed_valid = 1'b1; drive(1'b0, 1'b0, 12'h000); cyc();
        checks++; if (seed_ready !== 1'b0) begin errors++; $display("FAIL stg_stall: got %b want 0", seed_ready); end
        drive(1'b1, 1'b0, 12'h000); cyc();
        checks++; if (seed_ready !== 1'b1) begin errors++; $display("FAIL stg_ready_rise: got %b want 1", seed_ready); end
        drive(1'b0, 1'b1, 12'h000); cyc();
        seed_valid = 1'b0;
        checks++; if (o_data !== 12'h5A5) begin errors++; $display("FAIL stg_new_key: got %h want 5A5", o_data); end
        checks++; if (seed_ready !== 1'b0) begin errors++; $display("FAIL stg_second_taken: got %b want 0", seed_ready); end
        cyc();
        checks++; if (o_data !== 12'h2D2) begin errors++; $display("FAIL stg_step_key: got %h want 2D2", o_data); end
        drive(1'b0, 1'b0, 12'h000); cyc();
        drive(1'b1, 1'b0, 12'h000); cyc();
        drive(1'b0, 1'b1, 12'h000); cyc();
        checks++; if (o_data !== 12'h111) begin errors++; $display("FAIL stg_stalled_seed_key: got %h want 111", o_data); end
    endtask

    task automatic test_zero_seed_collision();
        drive(1'b0, 1'b0, 12'h000); cyc();
        seed_data = 12'h000; seed_valid = 1'b1; drive(1'b1, 1'b0, 12'h000); cyc();
        seed_valid = 1'b0;
        drive(1'b0, 1'b1, 12'h000); cyc();
        checks++; if (o_data !== 12'h111) begin errors++; $display("FAIL zs_old_active: got %h want 111", o_data); end
        checks++; if (seed_ready !== 1'b0) begin errors++; $display("FAIL zs_pending: got %b want 0", seed_ready); end
        drive(1'b0, 1'b0, 12'h000); cyc();
        drive(1'b1, 1'b0, 12'h000); cyc();
        drive(1'b0, 1'b1, 12'h000); cyc();
        checks++; if (o_data !== 12'h001) begin errors++; $display("FAIL zs_zero_replaced: got %h want 001", o_data); end
    endtask

    // lfsr is 0x800 here; the edge pixel registers 0x0F0 ^ 0x800 and stages 0x333.
    task automatic test_async_reset();
        seed_data = 12'h333; seed_valid = 1'b1; drive(1'b1, 1'b1, 12'h0F0); cyc();
        seed_valid = 1'b0;
        checks++; if (o_data !== 12'h8F0) begin errors++; $display("FAIL ar_pre_data: got %h want 8F0", o_data); end
        checks++; if (seed_ready !== 1'b0) begin errors++; $display("FAIL ar_pre_pending: got %b want 0", seed_ready); end
        drive(1'b1, 1'b1, 12'h0F0);
        #2 reset = 1'b0;
        #1;
        checks++; if (o_data !== 12'h000) begin errors++; $display("FAIL ar_o_data: got %h want 000", o_data); end
        checks++; if (o_href !== 1'b0) begin errors++; $display("FAIL ar_o_href: got %b want 0", o_href); end
        checks++; if (o_vsync !== 1'b0) begin errors++; $display("FAIL ar_o_vsync: got %b want 0", o_vsync); end
        checks++; if (seed_ready !== 1'b1) begin errors++; $display("FAIL ar_seed_ready: got %b want 1", seed_ready); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL ar_frame_cnt: got %0d want 0", frame_cnt); end
        drive(1'b0, 1'b0, 12'h000);
        cyc();
        reset = 1'b1;
        cyc();
        drive(1'b1, 1'b0, 12'h000); cyc();
        drive(1'b0, 1'b1, 12'h000); cyc();
        checks++; if (o_data !== 12'h001) begin errors++; $display("FAIL ar_first_key: got %h want 001", o_data); end
    endtask

    // Descrambler output after edge k must equal the pixel applied before edge k-1.
    task automatic test_round_trip();
        logic [W-1:0] prev_in;
        logic [W-1:0] cur_in;
        int           scrambled;
        reset = 1'b0; drive(1'b0, 1'b0, 12'h000); cyc();
        reset = 1'b1; cyc();
        prev_in   = 12'h000;
        scrambled = 0;
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 24; c++) begin
                cur_in = W'($urandom_range(0, 4095));
                drive((c == 0) || (c == 1), (c > 2) && ($urandom_range(0, 3) != 0), cur_in);
                cyc();
                if (i_href && (o_data !== cur_in)) scrambled++;
                checks++; if (d_data !== prev_in) begin errors++; $display("FAIL rt_f%0d_c%0d: got %h want %h", f, c, d_data, prev_in); end
                prev_in = cur_in;
            end
        end
        checks++; if (scrambled == 0) begin errors++; $display("FAIL rt_scrambled: got %0d scrambled pixels want >0", scrambled); end
        checks++; if (d_frame_cnt !== 16'd3) begin errors++; $display("FAIL rt_desc_frames: got %0d want 3", d_frame_cnt); end
    endtask

    initial begin
        no_seed_data = '0; no_seed_valid = 1'b0; desc_en = 1'b1;
        test_reset();
        test_keystream();
        test_free_run();
        test_bypass();
        test_vsync_collision();
        test_seed_staging();
        test_zero_seed_collision();
        test_async_reset();
        test_round_trip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
